// File: rtl/rf256x22_pkg.sv
// Shared types and constants for the 256x22 register-file controller.
// Covers the controller FSM states, requester ids and read-return slots.
package rf256x22_pkg;

  localparam int DW     = 22;
  localparam int AW     = 8;
  localparam int RA_W   = AW - 2;
  localparam int CA_W   = 2;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << AW;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_e;

  typedef enum logic {
    ID_A = 1'b0,
    ID_B = 1'b1
  } req_id_e;

  // One stage of the read-return tracker: a read is in flight and who owns it.
  typedef struct packed {
    logic    valid;
    req_id_e id;
  } rd_slot_t;

endpackage

// File: rtl/rf256x22_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Grants are combinational; the priority
// pointer moves only when the top reports that a grant was accepted.
module rr_arb2 (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  input  logic req_a,
  input  logic req_b,
  input  logic upd,
  output logic gnt_a,
  output logic gnt_b
);

  // High when B holds priority, i.e. A was the last requester accepted.
  logic prio_b;

  always_comb begin
    gnt_a = en & req_a & (~req_b | ~prio_b);
    gnt_b = en & req_b & (~req_a |  prio_b);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prio_b <= 1'b0;
    end else if (upd) begin
      prio_b <= gnt_a;
    end
  end

endmodule

// File: rtl/rf256x22_arbiter.sv
// Two-requester controller for the 256x22 single-port register-file macro:
// zero-fill after reset, round-robin access, flopped macro command, read return.
module rf256x22_arbiter
  import rf256x22_pkg::*;
#(
  parameter int            DW      = rf256x22_pkg::DW,
  parameter int            AW      = rf256x22_pkg::AW,
  parameter bit            CLR_EN  = 1'b1,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input  logic          CLK,
  input  logic          RST,

  input  logic          A_REQ,
  input  logic          A_WE,
  input  logic [AW-1:0] A_ADDR,
  input  logic [DW-1:0] A_WDATA,
  output logic          A_GNT,
  output logic          A_RVALID,
  output logic [DW-1:0] A_RDATA,

  input  logic          B_REQ,
  input  logic          B_WE,
  input  logic [AW-1:0] B_ADDR,
  input  logic [DW-1:0] B_WDATA,
  output logic          B_GNT,
  output logic          B_RVALID,
  output logic [DW-1:0] B_RDATA,

  output logic          CLR_BUSY,

  output logic          M_NCE,
  output logic          M_NWRT,
  output logic [AW-3:0] M_RA,
  output logic [1:0]    M_CA,
  output logic [DW-1:0] M_DIN,
  input  logic [DW-1:0] M_DO
);

  state_e        state, state_nxt;
  logic [AW-1:0] clr_cnt;
  logic          serve;
  logic          acc_a, acc_b;

  logic          cmd_valid;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_din;
  rd_slot_t      rd_new;
  rd_slot_t      rd_pipe [RD_LAT];
  rd_slot_t      rd_out;

  assign serve    = (state == ST_SERVE);
  assign CLR_BUSY = (state == ST_CLEAR);
  assign acc_a    = A_REQ & A_GNT;
  assign acc_b    = B_REQ & B_GNT;
  assign rd_out   = rd_pipe[RD_LAT-1];

  rr_arb2 u_arb (
    .CLK   (CLK),
    .RST   (RST),
    .en    (serve),
    .req_a (A_REQ),
    .req_b (B_REQ),
    .upd   (acc_a | acc_b),
    .gnt_a (A_GNT),
    .gnt_b (B_GNT)
  );

  // NOTE: every signal written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_cnt == '1) state_nxt = ST_SERVE;
      ST_SERVE: state_nxt = ST_SERVE;
      default:  state_nxt = ST_SERVE;
    endcase
  end

  // Select the command to register this cycle: fill write, A, B or idle.
  always_comb begin
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = clr_cnt;
    cmd_din   = CLR_VAL;
    rd_new    = '{valid: 1'b0, id: ID_A};
    if (state == ST_CLEAR) begin
      cmd_valid = 1'b1;
      cmd_wr    = 1'b1;
    end else if (acc_a) begin
      cmd_valid = 1'b1;
      cmd_wr    = A_WE;
      cmd_addr  = A_ADDR;
      cmd_din   = A_WDATA;
      rd_new    = '{valid: ~A_WE, id: ID_A};
    end else if (acc_b) begin
      cmd_valid = 1'b1;
      cmd_wr    = B_WE;
      cmd_addr  = B_ADDR;
      cmd_din   = B_WDATA;
      rd_new    = '{valid: ~B_WE, id: ID_B};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= CLR_EN ? ST_CLEAR : ST_SERVE;
      clr_cnt  <= '0;
      M_NCE    <= 1'b1;
      M_NWRT   <= 1'b1;
      M_RA     <= '0;
      M_CA     <= '0;
      M_DIN    <= '0;
      A_RVALID <= 1'b0;
      B_RVALID <= 1'b0;
      A_RDATA  <= '0;
      B_RDATA  <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '{valid: 1'b0, id: ID_A};
    end else begin
      state <= state_nxt;
      if (state == ST_CLEAR) clr_cnt <= clr_cnt + AW'(1);

      M_NCE  <= ~cmd_valid;
      M_NWRT <= ~(cmd_valid & cmd_wr);
      // Address and data only move on a real access to cut macro-pin toggling.
      if (cmd_valid) begin
        M_RA  <= cmd_addr[AW-1:2];
        M_CA  <= cmd_addr[1:0];
        M_DIN <= cmd_din;
      end

      rd_pipe[0] <= rd_new;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];

      A_RVALID <= rd_out.valid & (rd_out.id == ID_A);
      B_RVALID <= rd_out.valid & (rd_out.id == ID_B);
      if (rd_out.valid && rd_out.id == ID_A) A_RDATA <= M_DO;
      if (rd_out.valid && rd_out.id == ID_B) B_RDATA <= M_DO;
    end
  end

endmodule

// File: tb/tb_rf256x22_arbiter.sv
// Self-checking bench for rf256x22_arbiter with a behavioural macro model,
// a cycle model of grants/commands and a read-return scoreboard.
module tb_rf256x22_arbiter;

  localparam int DW = 22;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          A_REQ, A_WE, B_REQ, B_WE;
  logic [AW-1:0] A_ADDR, B_ADDR;
  logic [DW-1:0] A_WDATA, B_WDATA;
  logic          A_GNT, A_RVALID, B_GNT, B_RVALID, CLR_BUSY;
  logic [DW-1:0] A_RDATA, B_RDATA;
  logic          M_NCE, M_NWRT;
  logic [AW-3:0] M_RA;
  logic [1:0]    M_CA;
  logic [DW-1:0] M_DIN, M_DO;

  always #5 CLK = ~CLK;

  rf256x22_arbiter dut (
    .CLK(CLK), .RST(RST),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
    .CLR_BUSY(CLR_BUSY),
    .M_NCE(M_NCE), .M_NWRT(M_NWRT), .M_RA(M_RA), .M_CA(M_CA),
    .M_DIN(M_DIN), .M_DO(M_DO)
  );

  // Macro model: inputs registered at the clock edge, DO updated just after it.
  logic [DW-1:0] mem [256];
  always @(posedge CLK) begin
    if (!M_NCE) begin
      if (!M_NWRT) mem[{M_RA, M_CA}] <= M_DIN;
      else         M_DO <= mem[{M_RA, M_CA}];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef struct {
    int            due;
    logic          id;
    logic [DW-1:0] data;
  } sb_t;

  txn_t a_q[$], b_q[$];
  sb_t  sb[$];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Reference model state
  logic          armed = 1'b0;
  logic          m_clr, m_ptr_b;
  int            m_cnt;
  logic          e_nce, e_nwrt;
  logic [AW-3:0] e_ra;
  logic [1:0]    e_ca;
  logic [DW-1:0] e_din, e_rd_a, e_rd_b;
  logic [DW-1:0] shadow [256];
  logic          ea, eb, va, vb;
  logic          a_acc = 1'b0, b_acc = 1'b0;
  int            b_req_cyc = 0, b_gnt_cyc = 0;

  task automatic model_reset();
    m_clr = 1'b1; m_cnt = 0; m_ptr_b = 1'b0;
    e_nce = 1'b1; e_nwrt = 1'b1; e_ra = '0; e_ca = '0; e_din = '0;
    e_rd_a = '0; e_rd_b = '0;
    sb.delete();
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    armed = 1'b1;
  endtask

  task automatic model_step();
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    if (m_clr) begin
      e_nce = 1'b0; e_nwrt = 1'b0;
      {e_ra, e_ca} = m_cnt[AW-1:0];
      e_din = '0;
      if (m_cnt == 255) m_clr = 1'b0;
      m_cnt++;
    end else if (ea || eb) begin
      we   = ea ? A_WE    : B_WE;
      addr = ea ? A_ADDR  : B_ADDR;
      data = ea ? A_WDATA : B_WDATA;
      e_nce = 1'b0; e_nwrt = ~we;
      {e_ra, e_ca} = addr;
      e_din = data;
      if (!we) sb.push_back('{cyc + 3, eb, shadow[addr]});
      else     shadow[addr] = data;
      m_ptr_b = ea;
    end else begin
      e_nce = 1'b1; e_nwrt = 1'b1;
    end
  endtask

  // Monitor: compare DUT against model mid-cycle, then advance the model.
  always @(negedge CLK) begin
    ea = 1'b0; eb = 1'b0;
    if (armed) begin
      if (!m_clr) begin
        ea = A_REQ && (!B_REQ || !m_ptr_b);
        eb = B_REQ && (!A_REQ ||  m_ptr_b);
      end
      check("a_gnt", A_GNT, ea);
      check("b_gnt", B_GNT, eb);
      check("clr_busy", CLR_BUSY, m_clr);
      check("m_nce", M_NCE, e_nce);
      check("m_nwrt", M_NWRT, e_nwrt);
      check("m_ra", M_RA, e_ra);
      check("m_ca", M_CA, e_ca);
      check("m_din", M_DIN, e_din);
      va = (sb.size() > 0) && (sb[0].due == cyc) && (sb[0].id == 1'b0);
      vb = (sb.size() > 0) && (sb[0].due == cyc) && (sb[0].id == 1'b1);
      if (va) e_rd_a = sb[0].data;
      if (vb) e_rd_b = sb[0].data;
      if (va || vb) void'(sb.pop_front());
      check("a_rvalid", A_RVALID, va);
      check("b_rvalid", B_RVALID, vb);
      check("a_rdata", A_RDATA, e_rd_a);
      check("b_rdata", B_RDATA, e_rd_b);
      if (B_REQ === 1'b1) begin
        b_req_cyc++;
        if (B_GNT === 1'b1) b_gnt_cyc++;
      end
    end
    a_acc = (A_REQ === 1'b1) && (A_GNT === 1'b1) && !RST;
    b_acc = (B_REQ === 1'b1) && (B_GNT === 1'b1) && !RST;
    if (RST) model_reset();
    else if (armed) model_step();
  end

  // Driver: each requester holds its queue head until it is accepted.
  initial begin
    logic a_took, b_took;
    A_REQ = 0; A_WE = 0; A_ADDR = '0; A_WDATA = '0;
    B_REQ = 0; B_WE = 0; B_ADDR = '0; B_WDATA = '0;
    forever begin
      @(posedge CLK);
      a_took = a_acc; b_took = b_acc;
      #1;
      if (a_took && a_q.size() > 0) void'(a_q.pop_front());
      if (b_took && b_q.size() > 0) void'(b_q.pop_front());
      if (a_q.size() > 0) begin
        A_REQ = 1; A_WE = a_q[0].we; A_ADDR = a_q[0].addr; A_WDATA = a_q[0].data;
      end else A_REQ = 0;
      if (b_q.size() > 0) begin
        B_REQ = 1; B_WE = b_q[0].we; B_ADDR = b_q[0].addr; B_WDATA = b_q[0].data;
      end else B_REQ = 0;
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((a_q.size() > 0 || b_q.size() > 0 || sb.size() > 0 || A_REQ || B_REQ) && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    check(tag, n < 2000, 1'b1);
    repeat (2) @(negedge CLK);
  endtask

  task automatic count_clear(input string tag, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      if (CLR_BUSY === 1'b1) n++;
    end while (CLR_BUSY === 1'b1 && n < 400);
    check(tag, n, 256);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, g0, r0, w;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Fill after reset, then read the top address back as zero.
    count_clear("clr_len", n);
    a_q.push_back('{1'b0, 8'hFF, 22'h0});
    wait_idle("t1_idle");

    // Write then read the same address on consecutive accepts.
    a_q.push_back('{1'b1, 8'h13, 22'h2AAAAA});
    a_q.push_back('{1'b0, 8'h13, 22'h0});
    wait_idle("t2_idle");

    // Contending reads alternate between requesters.
    a_q.push_back('{1'b1, 8'h01, 22'h111111});
    b_q.push_back('{1'b1, 8'h02, 22'h222222});
    wait_idle("t3_fill");
    for (int i = 0; i < 4; i++) begin
      a_q.push_back('{1'b0, 8'h01, 22'h0});
      b_q.push_back('{1'b0, 8'h02, 22'h0});
    end
    wait_idle("t3_idle");

    // B streams reads alone: a grant on every requesting cycle.
    g0 = b_gnt_cyc; r0 = b_req_cyc;
    foreach (a_q[i]) ;
    b_q.push_back('{1'b0, 8'h01, 22'h0});
    b_q.push_back('{1'b0, 8'h02, 22'h0});
    b_q.push_back('{1'b0, 8'h13, 22'h0});
    b_q.push_back('{1'b0, 8'hFF, 22'h0});
    for (int i = 0; i < 4; i++) b_q.push_back('{1'b0, AW'(8'h20 + i), 22'h0});
    wait_idle("t4_idle");
    check("t4_b_gnt_cnt", b_gnt_cyc - g0, 8);
    check("t4_b_gnt_eq_req", b_gnt_cyc - g0, b_req_cyc - r0);

    // Reset with reads in flight; A request held across the new fill.
    a_q.push_back('{1'b1, 8'h00, 22'h000003});
    wait_idle("t5_wr");
    a_q.push_back('{1'b0, 8'h01, 22'h0});
    a_q.push_back('{1'b0, 8'h02, 22'h0});
    w = 0;
    do begin
      @(posedge CLK); #2; w++;
    end while (a_q.size() > 0 && w < 100);
    check("t5_issue", w < 100, 1'b1);
    RST = 1'b1;
    @(posedge CLK); #2;
    a_q.push_back('{1'b0, 8'h00, 22'h0});
    @(posedge CLK); #1 RST = 1'b0;
    count_clear("clr_len_rst", n);
    check("t6_gnt_first_serve", A_GNT, 1'b1);
    wait_idle("t6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
